// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch unit and control unit: NOP encoding, fetch FSM states,
// base opcodes. Define FETCH_MISALIGN_CHK_EN to add the ERR state for misaligned targets.
package riscv_pkg;

  localparam logic [31:0] INSN_NOP      = 32'h0000_0013;
  localparam logic [31:0] PC_STEP       = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    StFetch,
    StHold
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    StErr
`endif
  } fetch_state_e;

  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC adder: sequential step or taken branch offset, both modulo 2^32.
module pc_next
  import riscv_pkg::*;
(
  input  logic [31:0] pc_base_i,
  input  logic [31:0] imm_i,
  input  logic        taken_i,
  output logic [31:0] pc_next_o
);

  always_comb begin
    pc_next_o = taken_i ? (pc_base_i + imm_i) : (pc_base_i + PC_STEP);
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request a word, hold it for decode, then step or branch.
// Define FETCH_MISALIGN_CHK_EN to trap misaligned next-PC values in ERR with a misalign output.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] I,
  output logic [31:0] pc_out,
  output logic        valid,
  input  logic        ready,
  input  logic        PCsrc,
  input  logic [31:0] imm
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        misalign
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  insn_q, insn_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic         valid_q, valid_d;
  logic [31:0]  pc_calc;
`ifdef FETCH_MISALIGN_CHK_EN
  logic         misalign_q, misalign_d;
`endif

  // Branch target is relative to the instruction currently presented to decode.
  pc_next u_pc_next (
    .pc_base_i (pc_out_q),
    .imm_i     (imm),
    .taken_i   (PCsrc),
    .pc_next_o (pc_calc)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    insn_d   = insn_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
`ifdef FETCH_MISALIGN_CHK_EN
    misalign_d = misalign_q;
`endif
    unique case (state_q)
      StFetch: begin
        if (imem_ack) begin
          insn_d   = imem_rdata;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          state_d  = StHold;
        end
      end
      StHold: begin
        if (ready) begin
          valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
          if (!word_aligned(pc_calc)) begin
            misalign_d = 1'b1;
            state_d    = StErr;
          end else begin
            pc_d    = pc_calc;
            state_d = StFetch;
          end
`else
          pc_d    = pc_calc & PC_ALIGN_MASK;
          state_d = StFetch;
`endif
        end
      end
`ifdef FETCH_MISALIGN_CHK_EN
      StErr: begin
        state_d = StErr;
      end
`endif
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      insn_q   <= INSN_NOP;
      pc_out_q <= RESET_PC;
      valid_q  <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      insn_q   <= insn_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Gate with rst so no request escapes while the memory side is also being reset.
  assign imem_req  = (state_q == StFetch) && !rst;
  assign imem_addr = pc_q;
  assign I         = insn_q;
  assign pc_out    = pc_out_q;
  assign valid     = valid_q;
`ifdef FETCH_MISALIGN_CHK_EN
  assign misalign  = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for the main flow plus hand sequences for
// wait states, decode stalls, address wrap, mid-fetch reset and the misaligned-branch case.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] insn;
  logic [31:0] pc_out;
  logic        valid;
  logic        ready;
  logic        pcsrc;
  logic [31:0] imm;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (RST_PC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .I          (insn),
    .pc_out     (pc_out),
    .valid      (valid),
    .ready      (ready),
    .PCsrc      (pcsrc),
    .imm        (imm)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .misalign   (misalign)
`endif
  );

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        br;
    logic [31:0] off;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_insn;
    logic [31:0] e_pcout;
  } vec_t;

  function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic rdy,
                              input logic br, input logic [31:0] off, input logic e_req,
                              input logic [31:0] e_addr, input logic e_valid,
                              input logic [31:0] e_insn, input logic [31:0] e_pcout);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.rdy = rdy; v.br = br; v.off = off;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_insn = e_insn; v.e_pcout = e_pcout;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Address is only meaningful while a request is expected.
  task automatic check_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_valid, input logic [31:0] e_insn,
                           input logic [31:0] e_pcout);
    check({tag, ".req"}, {31'd0, imem_req}, {31'd0, e_req});
    if (e_req) check({tag, ".addr"}, imem_addr, e_addr);
    check({tag, ".valid"}, {31'd0, valid}, {31'd0, e_valid});
    check({tag, ".I"}, insn, e_insn);
    check({tag, ".pc_out"}, pc_out, e_pcout);
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic rdy,
                       input logic br, input logic [31:0] off);
    @(negedge clk);
    imem_ack = ack; imem_rdata = rdata; ready = rdy; pcsrc = br; imm = off;
    #1;
  endtask

  vec_t vecs[14];

  initial begin
    //              ack rdata          rdy br off           req addr         vld I             pc_out
    vecs[0]  = mk(1, 32'h0000_0013, 0, 0, 32'h0,        1, 32'h0,        0, NOP,          32'h0);
    vecs[1]  = mk(0, 32'h0,         1, 0, 32'h0,        0, 32'h0,        1, 32'h13,       32'h0);
    vecs[2]  = mk(1, 32'h0010_0093, 0, 0, 32'h0,        1, 32'h4,        0, 32'h13,       32'h0);
    vecs[3]  = mk(0, 32'h0,         1, 0, 32'h0,        0, 32'h0,        1, 32'h0010_0093, 32'h4);
    vecs[4]  = mk(1, 32'h0020_0113, 0, 0, 32'h0,        1, 32'h8,        0, 32'h0010_0093, 32'h4);
    vecs[5]  = mk(0, 32'h0,         1, 1, 32'h8,        0, 32'h0,        1, 32'h0020_0113, 32'h8);
    vecs[6]  = mk(1, 32'hAAAA_0013, 0, 0, 32'h0,        1, 32'h10,       0, 32'h0020_0113, 32'h8);
    vecs[7]  = mk(0, 32'h0,         1, 1, 32'hFFFF_FFF8, 0, 32'h0,       1, 32'hAAAA_0013, 32'h10);
    vecs[8]  = mk(0, 32'h0,         0, 0, 32'h0,        1, 32'h8,        0, 32'hAAAA_0013, 32'h10);
    vecs[9]  = mk(0, 32'h0,         1, 1, 32'h100,      1, 32'h8,        0, 32'hAAAA_0013, 32'h10);
    vecs[10] = mk(1, 32'h1234_5678, 0, 0, 32'h0,        1, 32'h8,        0, 32'hAAAA_0013, 32'h10);
    vecs[11] = mk(1, 32'h0000_DEAD, 0, 1, 32'h0,        0, 32'h0,        1, 32'h1234_5678, 32'h8);
    vecs[12] = mk(0, 32'h0,         1, 0, 32'h0,        0, 32'h0,        1, 32'h1234_5678, 32'h8);
    vecs[13] = mk(1, 32'h0000_0063, 0, 0, 32'h0,        1, 32'hC,        0, 32'h1234_5678, 32'h8);

    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; ready = 1'b0; pcsrc = 1'b0; imm = '0;
    @(negedge clk); #1;
    check("rst.req", {31'd0, imem_req}, 32'd0);
    @(negedge clk); #1;
    check_out("rst", 1'b0, RST_PC, 1'b0, NOP, RST_PC);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_out("rst_rel", 1'b1, RST_PC, 1'b0, NOP, RST_PC);

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].ack, vecs[i].rdata, vecs[i].rdy, vecs[i].br, vecs[i].off);
      check_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                vecs[i].e_insn, vecs[i].e_pcout);
    end

    // Memory wait states: request and address held, I untouched until ack.
    drive(0, 32'h0, 1, 0, 32'h0);
    check_out("a_ret", 1'b0, 32'h0, 1'b1, 32'h63, 32'hC);
    for (int i = 0; i < 5; i++) begin
      drive(0, 32'h0, 0, 0, 32'h0);
      check_out($sformatf("a_wait%0d", i), 1'b1, 32'h10, 1'b0, 32'h63, 32'hC);
    end
    drive(1, 32'h0000_0055, 0, 0, 32'h0);
    check_out("a_ack", 1'b1, 32'h10, 1'b0, 32'h63, 32'hC);

    // Decode stall with PCsrc toggling and stray acks: nothing moves until ready.
    for (int i = 0; i < 4; i++) begin
      drive(i[0], 32'h0000_0BAD, 0, ~i[0], 32'h40);
      check_out($sformatf("b_hold%0d", i), 1'b0, 32'h0, 1'b1, 32'h55, 32'h10);
    end
    drive(0, 32'h0, 1, 0, 32'h40);
    check_out("b_ready", 1'b0, 32'h0, 1'b1, 32'h55, 32'h10);
    drive(1, 32'h0000_0077, 0, 1, 32'h40);
    check_out("b_fetch", 1'b1, 32'h14, 1'b0, 32'h55, 32'h10);

    // Branch to the top word, then step across the 2^32 boundary.
    drive(0, 32'h0, 1, 1, 32'hFFFF_FFE8);
    check_out("c_br", 1'b0, 32'h0, 1'b1, 32'h77, 32'h14);
    drive(1, 32'h0000_0099, 0, 0, 32'h0);
    check_out("c_fetch", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h77, 32'h14);
    drive(0, 32'h0, 1, 0, 32'h0);
    check_out("c_ret", 1'b0, 32'h0, 1'b1, 32'h99, 32'hFFFF_FFFC);
    drive(1, 32'h0000_0011, 0, 0, 32'h0);
    check_out("c_wrap", 1'b1, 32'h0, 1'b0, 32'h99, 32'hFFFF_FFFC);
    drive(0, 32'h0, 1, 0, 32'h0);
    check_out("c_ret2", 1'b0, 32'h0, 1'b1, 32'h11, 32'h0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 32'h0, 0, 0, 32'h0);
      check_out($sformatf("c_wait%0d", i), 1'b1, 32'h4, 1'b0, 32'h11, 32'h0);
    end

    // Reset in the middle of a wait; an ack during reset must not be captured.
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0000_CAFE;
    #1;
    check("c_rst.req", {31'd0, imem_req}, 32'd0);
    @(negedge clk); #1;
    check_out("c_rst2", 1'b0, RST_PC, 1'b0, NOP, RST_PC);
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b0;
    #1;
    check_out("c_rel", 1'b1, RST_PC, 1'b0, NOP, RST_PC);

    // Taken branch with offset 6 from 0 lands on a misaligned target.
    drive(1, 32'h0000_0113, 0, 0, 32'h0);
    check_out("d_ack", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
    drive(0, 32'h0, 1, 1, 32'h6);
    check_out("d_ret", 1'b0, 32'h0, 1'b1, 32'h113, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h0000_0BAD, 1, 0, 32'h0);
      check_out($sformatf("d_err%0d", i), 1'b0, 32'h0, 1'b0, 32'h113, 32'h0);
      check($sformatf("d_err%0d.misalign", i), {31'd0, misalign}, 32'd1);
    end
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("d_clr.misalign", {31'd0, misalign}, 32'd0);
    check_out("d_clr", 1'b1, RST_PC, 1'b0, NOP, RST_PC);
`else
    drive(0, 32'h0, 0, 0, 32'h0);
    check_out("d_next", 1'b1, 32'h4, 1'b0, 32'h113, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset; synchronous and active-high.
REQ-004 The block SHALL have port imem_req, output, 1, the instruction-memory read request.
REQ-005 The block SHALL have port imem_addr, output, 32, the byte address of the requested word.
REQ-006 The block SHALL have port imem_ack, input, 1, indicating imem_rdata is valid this cycle.
REQ-007 The block SHALL have port imem_rdata, input, 32, the fetched instruction word.
REQ-008 The block SHALL have port I, output, 32, the instruction presented to CU/decode.
REQ-009 The block SHALL have port pc_out, output, 32, the address of the instruction on I.
REQ-010 The block SHALL have port valid, output, 1, indicating that I and pc_out hold a fetched instruction.
REQ-011 The block SHALL have port ready, input, 1, indicating that decode/execute retires I this cycle.
REQ-012 The block SHALL have port PCsrc, input, 1, the branch-taken flag from CU for the instruction on I.
REQ-013 The block SHALL have port imm, input, 32, the sign-extended B-type byte offset for the instruction on I.

Function
REQ-014 The block SHALL implement a 3-state FSM: FETCH, HOLD, ERR (ERR only when the macro is defined).
REQ-015 In FETCH: imem_req=1 and imem_addr=pc; imem_addr SHALL stay stable while imem_req=1.
REQ-016 In FETCH with imem_ack=1: I<=imem_rdata, pc_out<=pc, valid<=1 and next state HOLD; valid is asserted one cycle after ack.
REQ-017 In FETCH with imem_ack=0: the block SHALL hold all state; wait length is unbounded.
REQ-018 In HOLD: imem_req=0, and I, pc_out and valid SHALL stay stable until ready=1.
REQ-019 In HOLD with ready=1: pc<=PCsrc ? pc_out+imm : pc_out+4, valid<=0, next state FETCH.
REQ-020 PCsrc and imm SHALL be sampled only on the HOLD&ready cycle and ignored otherwise.
REQ-021 imem_ack outside FETCH SHALL be ignored.
REQ-022 Address arithmetic is modulo 2^32: pc 32'hFFFF_FFFC + 4 = 32'h0000_0000; a negative imm wraps identically.
REQ-023 Minimum throughput: one instruction per 3 cycles with zero-wait memory (ack in the req cycle).

Reset
REQ-024 When rst=1 at a clock edge: pc=RESET_PC, state=FETCH, I=32'h0000_0013 (NOP), pc_out=RESET_PC, valid=0, misalign=0.
REQ-025 imem_req SHALL be 0 during any cycle with rst=1.
REQ-026 rst=1 SHALL abandon any in-flight fetch; a late ack after reset release SHALL be accepted only if it belongs to the new FETCH state (memory is also reset by the same rst).

Configuration
REQ-027 Macro FETCH_MISALIGN_CHK_EN defined: a port misalign, output, 1, SHALL exist.
REQ-028 With FETCH_MISALIGN_CHK_EN defined: when the computed next pc has [1:0]!=2'b00, the block SHALL enter ERR with misalign=1, valid=0, imem_req=0, and remain there until rst.
REQ-029 Without FETCH_MISALIGN_CHK_EN: there is no misalign port and no ERR state; next pc[1:0] SHALL be forced to 2'b00.

Structure
REQ-030 Shared package riscv_pkg SHALL hold INSN_NOP (32'h0000_0013), the fetch state enum, and opcode constants shared with CU.
REQ-031 Next-PC computation (pc+4 / pc+imm mux) SHALL be a sub-module named pc_next; the FSM and registers stay in fetch_unit.

Verification
REQ-032 Reset, then zero-wait memory returning 0x00000013: imem_addr sequence 0x0, 0x4, 0x8; valid high one cycle after each ack.
REQ-033 In HOLD with pc_out=0x10, PCsrc=1, imm=-8 (0xFFFFFFF8), ready=1: next imem_addr=0x08.
REQ-034 Ack delayed 5 cycles: imem_addr constant and imem_req held for 5 cycles; I updates only after the ack.
REQ-035 ready=0 for 4 cycles in HOLD with PCsrc toggling: I/pc_out/valid unchanged; PCsrc ignored until ready=1, then the branch resolves from values on the ready cycle.
REQ-036 pc_out=0xFFFFFFFC, PCsrc=0, ready=1: next imem_addr=0x00000000; rst asserted mid-wait: imem_req=0 and the next fetch is from RESET_PC.
REQ-037 With FETCH_MISALIGN_CHK_EN, imm=0x6 taken from pc_out=0x0: misalign=1, imem_req stays 0 until rst; without the macro, imem_addr=0x4.
